seg7_mux_driver: RTL and testbench

Display-side counterpart to the keypad encoder in the calculator datapath. It accepts 8-bit results (ALU output or register-bank data) through a load strobe and renders them as two hexadecimal digits on a time-multiplexed common-cathode seven-segment display. Updates are double-buffered and committed only at frame boundaries, so a digit never shows half of an old value and half of a new one. It drives `uo_out` segment lines and digit-select lines.

---
 rtl/seg7_mux_driver.sv | 205 ++++++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver.sv
// Two-digit hex seven-segment scan driver with double-buffered updates.
// New values are committed only on frame boundaries (entries into DIG0).
module seg7_mux_driver #(
    parameter int   REFRESH_DIV    = 5000,
    parameter logic ACTIVE_LOW_SEG = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] value,
    input  logic       dp_in,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] dig_sel,
    output logic       upd_done
);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_DIG0 = 2'd1;
    localparam logic [1:0] S_DIG1 = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic        DP_OFF   = ACTIVE_LOW_SEG;

    logic [1:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        cnt_last;

    logic [7:0]  disp_val, disp_val_nxt;
    logic        disp_dp, disp_dp_nxt;
    logic        disp_blz, disp_blz_nxt;

    logic [7:0]  pend_val;
    logic        pend_dp;
    logic        pend_blz;
    logic        pend_valid;

    logic        frame_start;
    logic        commit;

    logic [3:0]  nibble;
    logic [6:0]  font_seg;
    logic [6:0]  seg_raw;
    logic        dp_raw;
    logic [1:0]  dig_sel_nxt;

    assign cnt_last = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = S_OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt = S_DIG0;
                    cnt_nxt   = '0;
                end
                S_DIG0: begin
                    if (cnt_last) begin
                        state_nxt = S_DIG1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                S_DIG1: begin
                    if (cnt_last) begin
                        state_nxt = S_DIG0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Any edge that moves into DIG0 starts a new frame.
    assign frame_start = (state_nxt == S_DIG0) && (state != S_DIG0);
    assign commit      = frame_start && (pend_valid || load);

    always_comb begin
        disp_val_nxt = disp_val;
        disp_dp_nxt  = disp_dp;
        disp_blz_nxt = disp_blz;
        if (commit) begin
            if (load) begin
                disp_val_nxt = value;
                disp_dp_nxt  = dp_in;
                disp_blz_nxt = blank_lz;
            end else begin
                disp_val_nxt = pend_val;
                disp_dp_nxt  = pend_dp;
                disp_blz_nxt = pend_blz;
            end
        end
    end

    assign nibble = (state_nxt == S_DIG1) ? disp_val_nxt[7:4] : disp_val_nxt[3:0];

    always_comb begin
        case (nibble)
            4'h0:    font_seg = 7'h3F;
            4'h1:    font_seg = 7'h06;
            4'h2:    font_seg = 7'h5B;
            4'h3:    font_seg = 7'h4F;
            4'h4:    font_seg = 7'h66;
            4'h5:    font_seg = 7'h6D;
            4'h6:    font_seg = 7'h7D;
            4'h7:    font_seg = 7'h07;
            4'h8:    font_seg = 7'h7F;
            4'h9:    font_seg = 7'h6F;
            4'hA:    font_seg = 7'h77;
            4'hB:    font_seg = 7'h7C;
            4'hC:    font_seg = 7'h39;
            4'hD:    font_seg = 7'h5E;
            4'hE:    font_seg = 7'h79;
            default: font_seg = 7'h71;
        endcase
    end

    // Outputs are decoded from next-state values so they register on the same edge as the FSM.
    always_comb begin
        seg_raw     = 7'h00;
        dp_raw      = 1'b0;
        dig_sel_nxt = 2'b00;
        case (state_nxt)
            S_DIG0: begin
                dig_sel_nxt = 2'b01;
                seg_raw     = font_seg;
                dp_raw      = disp_dp_nxt;
            end
            S_DIG1: begin
                dig_sel_nxt = 2'b10;
                seg_raw     = (disp_blz_nxt && (disp_val_nxt[7:4] == 4'h0)) ? 7'h00 : font_seg;
            end
            default: begin
                dig_sel_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= 1'b0;
            pend_blz   <= 1'b0;
            pend_valid <= 1'b0;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_blz   <= blank_lz;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val <= '0;
            disp_dp  <= 1'b0;
            disp_blz <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            disp_val <= disp_val_nxt;
            disp_dp  <= disp_dp_nxt;
            disp_blz <= disp_blz_nxt;
            upd_done <= commit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= SEG_OFF;
            dp      <= DP_OFF;
            dig_sel <= 2'b00;
        end else begin
            seg     <= ACTIVE_LOW_SEG ? ~seg_raw : seg_raw;
            dp      <= ACTIVE_LOW_SEG ? ~dp_raw : dp_raw;
            dig_sel <= dig_sel_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: expected per-cycle outputs are queued
// by the stimulus process and checked by an independent negedge monitor.
module tb_seg7_mux_driver;

    logic       clk = 1'b0;
    logic       rst_n, en, load, dp_in, blank_lz;
    logic [7:0] value;
    logic [6:0] seg;
    logic       dp, upd_done;
    logic [1:0] dig_sel;

    logic       rst2_n, en2, load2, dp2_in, blank2_lz;
    logic [7:0] value2;
    logic [6:0] seg2;
    logic       dp2, upd2_done;
    logic [1:0] dig2_sel;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         c;
        int         which;
        logic [1:0] ds;
        logic [6:0] sg;
        logic       d;
        logic       u;
    } exp_t;

    exp_t sb[$];

    seg7_mux_driver #(.REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp),
        .dig_sel(dig_sel), .upd_done(upd_done)
    );

    seg7_mux_driver #(.REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b1)) dut_al (
        .clk(clk), .rst_n(rst2_n), .en(en2), .load(load2), .value(value2),
        .dp_in(dp2_in), .blank_lz(blank2_lz), .seg(seg2), .dp(dp2),
        .dig_sel(dig2_sel), .upd_done(upd2_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] a_ds;
        logic [6:0] a_sg;
        logic       a_d, a_u;
        string      nm;
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.which == 0) begin
                a_ds = dig_sel; a_sg = seg; a_d = dp; a_u = upd_done; nm = "dut";
            end else begin
                a_ds = dig2_sel; a_sg = seg2; a_d = dp2; a_u = upd2_done; nm = "dut_al";
            end
            if (e.c != cyc) begin
                n_fail++;
                $display("FAIL %s missed_check cyc=%0d got_at=%0d", nm, e.c, cyc);
            end else if (a_ds !== e.ds || a_sg !== e.sg || a_d !== e.d || a_u !== e.u) begin
                n_fail++;
                $display("FAIL %s outputs cyc=%0d actual dig_sel=%b seg=%h dp=%b upd=%b required dig_sel=%b seg=%h dp=%b upd=%b",
                         nm, cyc, a_ds, a_sg, a_d, a_u, e.ds, e.sg, e.d, e.u);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    // Push expectations for cycles c0..c1; upd_done required only on c0 when u0 is set.
    task automatic expect_range(input int which, input int c0, input int c1,
                                input logic [1:0] ds, input logic [6:0] sg,
                                input logic d, input logic u0);
        for (int c = c0; c <= c1; c++) begin
            exp_t e;
            e.c = c; e.which = which; e.ds = ds; e.sg = sg; e.d = d;
            e.u = (c == c0) ? u0 : 1'b0;
            sb.push_back(e);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 8'h00; dp_in = 1'b0; blank_lz = 1'b0;
        rst2_n = 1'b0; en2 = 1'b0; load2 = 1'b0; value2 = 8'h00; dp2_in = 1'b0; blank2_lz = 1'b0;

        // Reset state of both instances
        expect_range(0, 2, 2, 2'b00, 7'h00, 1'b0, 1'b0);
        expect_range(1, 2, 2, 2'b00, 7'h7F, 1'b1, 1'b0);
        expect_range(0, 3, 3, 2'b00, 7'h00, 1'b0, 1'b0);
        expect_range(1, 3, 3, 2'b00, 7'h7F, 1'b1, 1'b0);
        go_to(3);
        rst_n = 1'b1;
        en    = 1'b1;

        // Scan of value 00: DIG0 4..7, DIG1 8..11, DIG0 12..15, DIG1 16
        expect_range(0, 4, 7, 2'b01, 7'h3F, 1'b0, 1'b0);
        expect_range(0, 8, 11, 2'b10, 7'h3F, 1'b0, 1'b0);
        expect_range(0, 12, 15, 2'b01, 7'h3F, 1'b0, 1'b0);
        expect_range(0, 16, 16, 2'b10, 7'h3F, 1'b0, 1'b0);

        // Load 3A dp during DIG1: held until DIG0 entry at 20
        go_to(16);
        expect_range(0, 17, 19, 2'b10, 7'h3F, 1'b0, 1'b0);
        expect_range(0, 20, 23, 2'b01, 7'h77, 1'b1, 1'b1);
        expect_range(0, 24, 27, 2'b10, 7'h4F, 1'b0, 1'b0);
        load = 1'b1; value = 8'h3A; dp_in = 1'b1;
        go_to(17);
        load = 1'b0; dp_in = 1'b0;

        // Two loads in one frame: last wins, one upd_done at 36
        go_to(28);
        expect_range(0, 28, 31, 2'b01, 7'h77, 1'b1, 1'b0);
        expect_range(0, 32, 35, 2'b10, 7'h4F, 1'b0, 1'b0);
        expect_range(0, 36, 39, 2'b01, 7'h66, 1'b0, 1'b1);
        expect_range(0, 40, 43, 2'b10, 7'h4F, 1'b0, 1'b0);
        load = 1'b1; value = 8'h12;
        go_to(29);
        load = 1'b0;
        go_to(32);
        load = 1'b1; value = 8'h34;
        go_to(33);
        load = 1'b0;

        // Bypass load of 07 with blanking on the DIG1->DIG0 edge at 52
        go_to(44);
        expect_range(0, 44, 47, 2'b01, 7'h66, 1'b0, 1'b0);
        expect_range(0, 48, 51, 2'b10, 7'h4F, 1'b0, 1'b0);
        expect_range(0, 52, 55, 2'b01, 7'h07, 1'b0, 1'b1);
        expect_range(0, 56, 59, 2'b10, 7'h00, 1'b0, 1'b0);
        go_to(51);
        load = 1'b1; value = 8'h07; blank_lz = 1'b1;
        go_to(52);
        load = 1'b0; blank_lz = 1'b0;

        // Disable mid-DIG0, load FF while OFF, re-enable commits at 67
        go_to(60);
        expect_range(0, 60, 61, 2'b01, 7'h07, 1'b0, 1'b0);
        expect_range(0, 62, 66, 2'b00, 7'h00, 1'b0, 1'b0);
        expect_range(0, 67, 70, 2'b01, 7'h71, 1'b0, 1'b1);
        expect_range(0, 71, 74, 2'b10, 7'h71, 1'b0, 1'b0);
        expect_range(0, 75, 75, 2'b01, 7'h71, 1'b0, 1'b0);
        go_to(61);
        en = 1'b0;
        go_to(63);
        load = 1'b1; value = 8'hFF;
        go_to(64);
        load = 1'b0;
        go_to(66);
        en = 1'b1;

        // Active-low instance: 88 bypass-committed on first enable, then reset mid-frame
        go_to(76);
        expect_range(1, 77, 80, 2'b01, 7'h00, 1'b1, 1'b1);
        expect_range(1, 81, 83, 2'b10, 7'h00, 1'b1, 1'b0);
        expect_range(1, 84, 85, 2'b00, 7'h7F, 1'b1, 1'b0);
        expect_range(1, 86, 87, 2'b01, 7'h40, 1'b1, 1'b0);
        rst2_n = 1'b1; en2 = 1'b1; load2 = 1'b1; value2 = 8'h88;
        go_to(77);
        load2 = 1'b0;
        go_to(82);
        load2 = 1'b1; value2 = 8'h55;
        go_to(83);
        load2 = 1'b0;
        go_to(84);
        rst2_n = 1'b0;
        go_to(85);
        rst2_n = 1'b1;

        go_to(92);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL unchecked_entry cyc=%0d which=%0d", e.c, e.which);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
